// File: rtl/data_memory_responder.sv
// Word-serial backing memory for the data cache miss path: answers line refills
// and dirty-line writebacks behind a busywait handshake with a fixed latency.
module data_memory_responder #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINE_ADDR_W    = 28,
  parameter int DEPTH_LINES    = 256,
  parameter int LATENCY        = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             mem_read_i,
  input  logic                             mem_write_i,
  input  logic [LINE_ADDR_W-1:0]           mem_address_i,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] mem_writedata_i,
  output logic [WORD_W*WORDS_PER_LINE-1:0] mem_readdata_o,
  output logic                             mem_busywait_o
);

  localparam int IDX_W     = $clog2(DEPTH_LINES);
  localparam int BEAT_W    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int ARR_WORDS = DEPTH_LINES * WORDS_PER_LINE;
  localparam int ARR_AW    = $clog2(ARR_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT,
    S_DONE
  } state_t;

  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BEAT_W-1:0] r_beat;
  logic [IDX_W-1:0]  r_index;
  logic              r_is_write;
  line_t             r_buf;
  line_t             r_readdata;
  logic [WORD_W-1:0] r_mem [ARR_WORDS];

  logic              w_req;
  logic              w_last_beat;
  logic [ARR_AW-1:0] w_arr_addr;
  line_t             w_buf_next;

  assign w_req       = mem_read_i | mem_write_i;
  assign w_last_beat = (r_beat == BEAT_W'(WORDS_PER_LINE - 1));
  assign w_arr_addr  = ARR_AW'(r_index) * ARR_AW'(WORDS_PER_LINE) + ARR_AW'(r_beat);

  // Upper line-address bits are deliberately ignored, so addresses alias.
  if (LINE_ADDR_W > IDX_W) begin : g_alias
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^mem_address_i[LINE_ADDR_W-1:IDX_W];
  end

  // Line buffer with the current beat's array word merged in, so the final
  // read beat reaches mem_readdata_o on the same edge that enters DONE.
  always_comb begin
    // NOTE: default the whole vector first; an always_comb that skips an
    // assignment on some path infers a latch.
    w_buf_next         = r_buf;
    w_buf_next[r_beat] = r_mem[w_arr_addr];
  end

  assign mem_busywait_o = (r_state == S_IDLE) ? w_req
                        : (r_state == S_WAIT) || (r_state == S_BEAT);
  assign mem_readdata_o = r_readdata;

  // NOTE: the storage array has no reset; contents survive rst_i, including
  // beats already committed by an aborted writeback.
  always_ff @(posedge clk_i) begin
    if (r_state == S_BEAT && r_is_write) begin
      r_mem[w_arr_addr] <= r_buf[r_beat];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_beat     <= '0;
      r_index    <= '0;
      r_is_write <= 1'b0;
      r_buf      <= '0;
      r_readdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state    <= S_WAIT;
            r_index    <= mem_address_i[IDX_W-1:0];
            r_is_write <= mem_write_i;
            r_buf      <= mem_writedata_i;
            r_cnt      <= CNT_W'(LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_BEAT;
            r_beat  <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_BEAT: begin
          if (!r_is_write) begin
            r_buf <= w_buf_next;
          end
          if (w_last_beat) begin
            r_state <= S_DONE;
            if (!r_is_write) begin
              r_readdata <= w_buf_next;
            end
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: stimulus pushes expected busy length
// and read line per transfer; a monitor pops and compares when busywait falls.
module tb_data_memory_responder;

  localparam int WORD_W = 32;
  localparam int WPL    = 4;
  localparam int LAW    = 28;
  localparam int DEPTH  = 256;
  localparam int LAT    = 4;
  localparam int LINE_W = WORD_W * WPL;
  localparam int OP_LEN = LAT + WPL + 1;

  typedef logic [LINE_W-1:0] line_t;
  typedef struct {
    line_t rd;
    int    len;
    int    id;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_a, rd_a, wr_a, busy_a;
  logic [LAW-1:0] addr_a;
  line_t          wdata_a, rdata_a;

  logic           rst_b, rd_b, wr_b, busy_b;
  logic [LAW-1:0] addr_b;
  logic [31:0]    wdata_b, rdata_b;

  data_memory_responder #(
    .WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .LINE_ADDR_W(LAW),
    .DEPTH_LINES(DEPTH), .LATENCY(LAT)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .mem_read_i(rd_a), .mem_write_i(wr_a),
    .mem_address_i(addr_a), .mem_writedata_i(wdata_a),
    .mem_readdata_o(rdata_a), .mem_busywait_o(busy_a)
  );

  data_memory_responder #(
    .WORD_W(32), .WORDS_PER_LINE(1), .LINE_ADDR_W(LAW),
    .DEPTH_LINES(DEPTH), .LATENCY(1)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .mem_read_i(rd_b), .mem_write_i(wr_b),
    .mem_address_i(addr_b), .mem_writedata_i(wdata_b),
    .mem_readdata_o(rdata_b), .mem_busywait_o(busy_b)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  int    op_id    = 0;
  exp_t  exp_q[$];
  line_t model_mem[int];
  line_t model_rd;

  task automatic check(input string name, input line_t got, input line_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic int idx_of(input logic [LAW-1:0] a);
    return int'(a % DEPTH);
  endfunction

  // Reference model: a write replaces the whole line, a read returns it; the
  // visible read line only changes when a read completes.
  task automatic expect_op(input bit rd, input bit wr, input logic [LAW-1:0] a, input line_t d);
    exp_t e;
    if (wr) model_mem[idx_of(a)] = d;
    else if (rd) model_rd = model_mem[idx_of(a)];
    e.rd  = model_rd;
    e.len = OP_LEN;
    e.id  = op_id++;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    @(negedge clk);
    while (busy_a === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("timeout_a", LINE_W'(busy_a), '0);
    rd_a = 1'b0;
    wr_a = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic op_a(input bit rd, input bit wr, input logic [LAW-1:0] a, input line_t d);
    expect_op(rd, wr, a, d);
    rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d;
    wait_idle_a();
  endtask

  task automatic op_b(input bit rd, input bit wr, input logic [LAW-1:0] a,
                      input logic [31:0] d, output int len);
    len = 0;
    rd_b = rd; wr_b = wr; addr_b = a; wdata_b = d;
    @(negedge clk);
    while (busy_b === 1'b1 && len < 64) begin
      len++;
      @(negedge clk);
    end
    rd_b = 1'b0;
    wr_b = 1'b0;
    @(posedge clk); #1;
  endtask

  int run_a = 0;
  always @(negedge clk) begin : monitor_a
    exp_t e;
    if (busy_a === 1'b1) begin
      run_a++;
    end else if (run_a > 0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_op", LINE_W'(run_a), '0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("sb_op%0d_busy_len", e.id), LINE_W'(run_a), LINE_W'(e.len));
        check($sformatf("sb_op%0d_rdata", e.id), rdata_a, e.rd);
      end
      run_a = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    line_t l5, l6, la5, p, q, r, dd, o8, w8;
    logic [31:0] ob, wb;
    int len;

    rst_a = 1'b1; rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
    rst_b = 1'b1; rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
    model_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata_a", rdata_a, '0);
    check("reset_busy_a", LINE_W'(busy_a), '0);
    check("reset_rdata_b", LINE_W'(rdata_b), '0);
    check("reset_busy_b", LINE_W'(busy_b), '0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Write then read with default parameters.
    l5 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    op_a(1'b0, 1'b1, 28'h005, l5);
    op_a(1'b1, 1'b0, 28'h005, '0);
    check("wr_rd_05", rdata_a, 128'h44444444_33333333_22222222_11111111);

    // Aliasing through the ignored upper address bits.
    l6  = {4{32'h06060606}};
    la5 = {4{32'hA5A5A5A5}};
    op_a(1'b0, 1'b1, 28'h006, l6);
    op_a(1'b0, 1'b1, 28'h105, la5);
    op_a(1'b1, 1'b0, 28'h005, '0);
    check("alias_005", rdata_a, la5);
    op_a(1'b1, 1'b0, 28'h006, '0);
    check("alias_06_untouched", rdata_a, l6);

    // Inputs change and the request drops at cycle 2; the original write completes.
    p = {4{32'h50505050}};
    q = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    r = {4{32'hBADBAD00}};
    op_a(1'b0, 1'b1, 28'h031, p);
    expect_op(1'b0, 1'b1, 28'h030, q);
    wr_a = 1'b1; addr_a = 28'h030; wdata_a = q;
    repeat (2) begin @(posedge clk); #1; end
    addr_a = 28'h031; wdata_a = r; wr_a = 1'b0;
    wait_idle_a();
    op_a(1'b1, 1'b0, 28'h030, '0);
    check("stable_30", rdata_a, q);
    op_a(1'b1, 1'b0, 28'h031, '0);
    check("stable_31", rdata_a, p);

    // Read+write together, request held through DONE and into the next IDLE.
    dd = {4{32'hDEADBEEF}};
    expect_op(1'b1, 1'b1, 28'h007, dd);
    rd_a = 1'b1; wr_a = 1'b1; addr_a = 28'h007; wdata_a = dd;
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk);
    check("done_no_retrigger", LINE_W'(busy_a), '0);
    check("both_rdata_kept", rdata_a, model_rd);
    @(posedge clk); #1;
    @(negedge clk);
    check("rerise_c10", LINE_W'(busy_a), LINE_W'(1));
    expect_op(1'b1, 1'b1, 28'h007, dd);
    @(posedge clk); #1;
    rd_a = 1'b0; wr_a = 1'b0; wdata_a = '0;
    wait_idle_a();
    @(negedge clk);
    check("no_rerise_after_drop", LINE_W'(busy_a), '0);
    @(posedge clk); #1;
    op_a(1'b1, 1'b0, 28'h007, '0);
    check("both_wrote_07", rdata_a, dd);

    // Randomized traffic over a small index range with random aliasing bits.
    for (int i = 0; i < 24; i++) begin
      logic [LAW-1:0] a;
      line_t          d;
      bit             do_rd;
      a     = LAW'($urandom_range(0, 15)) | (LAW'($urandom) << 8);
      d     = {$urandom, $urandom, $urandom, $urandom};
      do_rd = model_mem.exists(idx_of(a)) && ($urandom_range(0, 1) == 1);
      if (do_rd) op_a(1'b1, 1'b0, a, '0);
      else op_a($urandom_range(0, 3) == 0, 1'b1, a, d);
    end

    // Reset during beat 1 of a writeback: beats 0 and 1 stick, 2 and 3 keep old data.
    o8 = {$urandom, $urandom, $urandom, $urandom};
    w8 = {$urandom, $urandom, $urandom, $urandom};
    op_a(1'b0, 1'b1, 28'h008, o8);
    begin
      exp_t e;
      model_rd = '0;
      model_mem[8] = {o8[127:64], w8[63:0]};
      e.rd  = '0;
      e.len = LAT + 3;
      e.id  = op_id++;
      exp_q.push_back(e);
    end
    wr_a = 1'b1; addr_a = 28'h008; wdata_a = w8;
    repeat (LAT + 2) begin @(posedge clk); #1; end
    rst_a = 1'b1; wr_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", LINE_W'(busy_a), '0);
    check("rst_mid_rdata", rdata_a, '0);
    @(posedge clk); #1;
    op_a(1'b1, 1'b0, 28'h008, '0);
    check("rst_mid_partial", rdata_a, {o8[127:64], w8[63:0]});

    // LATENCY=1, one word per line.
    ob = $urandom;
    wb = ~ob;
    op_b(1'b0, 1'b1, 28'h003, ob, len);
    check("b_wr_busy_len", LINE_W'(len), LINE_W'(3));
    check("b_wr_rdata_unchanged", LINE_W'(rdata_b), '0);
    op_b(1'b1, 1'b0, 28'h003, '0, len);
    check("b_rd_busy_len", LINE_W'(len), LINE_W'(3));
    check("b_rd_data", LINE_W'(rdata_b), LINE_W'(ob));
    wr_b = 1'b1; addr_b = 28'h003; wdata_b = wb;
    repeat (2) begin @(posedge clk); #1; end
    rst_b = 1'b1; wr_b = 1'b0;
    @(negedge clk);
    check("b_busy_in_beat", LINE_W'(busy_b), LINE_W'(1));
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    check("b_rst_busy", LINE_W'(busy_b), '0);
    check("b_rst_rdata", LINE_W'(rdata_b), '0);
    @(posedge clk); #1;
    op_b(1'b1, 1'b0, 28'h003, '0, len);
    check("b_rst_word_kept", LINE_W'(rdata_b), LINE_W'(wb));
    check("b_rd2_busy_len", LINE_W'(len), LINE_W'(3));

    repeat (2) @(posedge clk);
    check("sb_queue_drained", LINE_W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Backing-memory responder for the data cache's miss path: it answers line-refill reads and dirty-line writebacks using the cache's busywait handshake. It sits below `data_cache`, on the side facing away from the pipeline, and models a word-serial memory with a fixed access latency. Line data is moved one word per cycle through an internal line buffer. Storage is a word-organised array.

## Interface
Parameters:
- `WORD_W`, 32, bits per word
- `WORDS_PER_LINE`, 4, words per cache line (power of two, ≥1)
- `LINE_ADDR_W`, 28, width of the line address
- `DEPTH_LINES`, 256, number of stored lines (power of two)
- `LATENCY`, 4, wait cycles before the first beat (≥1)

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset. One clock; reset is synchronous and active-high.
- `mem_read_i` input 1: line read request, held by the cache while busywait is high.
- `mem_write_i` input 1: line write request, held by the cache while busywait is high.
- `mem_address_i` input LINE_ADDR_W: line address. The index is the low log2(DEPTH_LINES) bits; upper bits are ignored, so addresses alias.
- `mem_writedata_i` input WORD_W*WORDS_PER_LINE: write line. Word 0 occupies the LSBs.
- `mem_readdata_o` output WORD_W*WORDS_PER_LINE: read line. It is registered.
- `mem_busywait_o` output 1: transfer in progress.

## Operation
- The FSM has four states: IDLE, WAIT, BEAT and DONE.
- **IDLE → WAIT** when `mem_read_i | mem_write_i`.
  - At that edge the block latches the address, the op (write has priority if both are high; the read is then dropped) and `mem_writedata_i` into the line buffer.
  - The wait counter loads LATENCY-1.
- **WAIT**: the counter decrements each cycle. WAIT → BEAT at the edge where the counter is 0. The beat index loads 0.
- **BEAT**: one word per cycle at array index {line_index, beat}.
  - On a write, buffer word[beat] is written to the array.
  - On a read, the array word is written to buffer word[beat].
  - BEAT → DONE after beat WORDS_PER_LINE-1.
- **DONE**: on a read, `mem_readdata_o` ← line buffer at the DONE entry edge. The next edge always goes to IDLE. Requests present in DONE are ignored.
- `mem_busywait_o` is combinational. It is 1 when:
  - the state is IDLE and (`mem_read_i | mem_write_i`), or
  - the state is WAIT or BEAT.

  It is 0 in DONE and when IDLE has no request.
- Input changes after the IDLE sampling edge are ignored. A request deasserted mid-transfer still completes.
- `mem_readdata_o` holds its value until the next completed read. Writes never change it.
- Reset applies from any state:
  - the state returns to IDLE;
  - counters clear;
  - `mem_readdata_o` is set to 0;
  - `mem_busywait_o` is 0 unless a request is present in the same cycle, because it is combinational;
  - array contents are preserved, and a write aborted mid-BEAT leaves the words already written.
- Array contents after power-up are undefined. Benches write before reading.
- No byte enables. Sub-line writes are the cache's job.

## Timing
- Request first seen in IDLE at cycle 0. `mem_busywait_o` is high in cycles 0 … LATENCY+WORDS_PER_LINE, i.e. LATENCY+WORDS_PER_LINE+1 cycles.
- WAIT occupies cycles 1 … LATENCY. BEAT occupies LATENCY+1 … LATENCY+WORDS_PER_LINE. DONE is cycle LATENCY+WORDS_PER_LINE+1.
- With defaults, busywait is high in cycles 0–8, DONE is cycle 9 and IDLE is cycle 10.
- Read data is valid from the start of DONE. The cache samples it at the DONE edge.
- Back-to-back requests: the earliest next acceptance is cycle DONE+1 (IDLE), so the minimum spacing is LATENCY+WORDS_PER_LINE+2 cycles.
- A write followed by a read of the same line returns the new data: the write array updates complete in BEAT before DONE.

## Test plan
- **Reset values**: hold `rst_i`=1 for 2 cycles with no request → `mem_readdata_o`=0 and `mem_busywait_o`=0; the state is IDLE.
- **Write then read, defaults**:
  - Stimulus: write line 0x05 with words {0x11111111, 0x22222222, 0x33333333, 0x44444444} (word 0 first), then read line 0x05.
  - Response: busywait is high for exactly 9 cycles per op, and the read returns 0x44444444_33333333_22222222_11111111 at DONE.
- **Aliasing**: write line 0x105 with 0xA5A5… (DEPTH_LINES=256), then read line 0x005 → returns 0xA5A5…; the read of line 0x06 is unchanged.
- **Input stability**: after acceptance, change `mem_address_i` and `mem_writedata_i` and drop `mem_write_i` at cycle 2 → the original line and data are written; busywait still falls at cycle 9.
- **Simultaneous read+write and DONE hold**:
  - Stimulus: assert both for line 0x07 with data 0xDEAD…; keep the request high through DONE.
  - Response: the write is performed, `mem_readdata_o` is unchanged, there is no retrigger in DONE, and busywait re-rises at cycle 10 only if the request is still high.
- **Reset mid-operation**:
  - Stimulus: during BEAT beat 1 of a write of {W0..W3} to line 0x08 over old contents {O0..O3}, assert `rst_i` for one cycle.
  - Response: busywait drops, `mem_readdata_o`=0, and a subsequent read of 0x08 returns {W0, W1, O2, O3}.
  - Repeat with LATENCY=1 and WORDS_PER_LINE=1: busywait is high for 3 cycles.
